multicycle_control: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS control decoder.
- Owns an instruction register and a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake and on a configurable multi-cycle mul/div latency.
- Sits between the instruction/data memory port and the existing datapath: ALU, register file, PC mux.

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/ctrl_decode.sv | 63 ++++++
 rtl/multicycle_control.sv | 170 +++++++++++++++++
 tb/tb_multicycle_control.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle MIPS control unit.
//   state_e   - FSM states (S_TRAP only reachable with CTRL_ILLEGAL_TRAP_EN)
//   iclass_e  - instruction class produced by ctrl_decode
//   OP_*      - primary opcodes, F_* - R-type funct codes, ALU_* - alu_op codes
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MULDIV, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_RTYPE, CLS_MULDIV, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_DIV  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_JUMP = 4'b1111;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decoder.
//   ir     in  INSTR_W  instruction register
//   cls    out          instruction class (CLS_NONE when unrecognised)
//   alu_op out  4       ALU operation code (0 when unrecognised)
//   shamt  out  SHAMT_W shift amount for sll/srl/sra, else 0
//   legal  out  1       instruction is recognised
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [INSTR_W-1:0] ir,
  output iclass_e            cls,
  output logic [3:0]         alu_op,
  output logic [SHAMT_W-1:0] shamt,
  output logic               legal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode = ir[INSTR_W-1 -: 6];
  assign funct  = ir[5:0];
  // Register-number and immediate fields belong to the datapath, not to control.
  assign unused_bits = ^ir[INSTR_W-7:6+SHAMT_W];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    cls    = CLS_NONE;
    alu_op = ALU_AND;
    shamt  = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:  begin cls = CLS_RTYPE;  alu_op = ALU_ADD; end
          F_SUB:  begin cls = CLS_RTYPE;  alu_op = ALU_SUB; end
          F_AND:  begin cls = CLS_RTYPE;  alu_op = ALU_AND; end
          F_OR:   begin cls = CLS_RTYPE;  alu_op = ALU_OR;  end
          F_XOR:  begin cls = CLS_RTYPE;  alu_op = ALU_XOR; end
          F_NOR:  begin cls = CLS_RTYPE;  alu_op = ALU_NOR; end
          F_SLT:  begin cls = CLS_RTYPE;  alu_op = ALU_SLT; end
          F_SLL:  begin cls = CLS_RTYPE;  alu_op = ALU_SLL; shamt = ir[6 +: SHAMT_W]; end
          F_SRL:  begin cls = CLS_RTYPE;  alu_op = ALU_SRL; shamt = ir[6 +: SHAMT_W]; end
          F_SRA:  begin cls = CLS_RTYPE;  alu_op = ALU_SRA; shamt = ir[6 +: SHAMT_W]; end
          F_MULT: begin cls = CLS_MULDIV; alu_op = ALU_MUL; end
          F_DIV:  begin cls = CLS_MULDIV; alu_op = ALU_DIV; end
          default: ;
        endcase
      end
      OP_LW:   begin cls = CLS_LW;  alu_op = ALU_ADD;  end
      OP_SW:   begin cls = CLS_SW;  alu_op = ALU_ADD;  end
      OP_BEQ:  begin cls = CLS_BEQ; alu_op = ALU_SUB;  end
      OP_BNE:  begin cls = CLS_BNE; alu_op = ALU_SUB;  end
      OP_J:    begin cls = CLS_J;   alu_op = ALU_JUMP; end
      default: ;
    endcase
  end

  assign legal = (cls != CLS_NONE);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control unit (IR + sequencing FSM).
// Sequences fetch/decode/exec/muldiv/mem/writeback, stalling on mem_ready and
// on a MULDIV_LAT-cycle mul/div. Strobes are decoded from the registered state
// and IR, plus mem_ready (fetch/mem) and zero (branch) in the same cycle.
// Optional: define CTRL_ILLEGAL_TRAP_EN to add illegal_op and the S_TRAP state;
// otherwise unrecognised instructions act as NOPs.
// Ports: clk, reset (sync, active-high), instr_in, mem_ready, zero -> instr,
//   alu_op, shift_amount, pc_write, ir_write, jumpSrc, PCSrc, RegWrite,
//   MemWrite, MemtoReg, MemRead, RegDst, ALUSrc, busy_muldiv [, illegal_op].
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ALUOP_W    = 4,
  parameter int SHAMT_W    = 5,
  parameter int MULDIV_LAT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               mem_ready,
  input  logic               zero,
  output logic [INSTR_W-1:0] instr,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [SHAMT_W-1:0] shift_amount,
  output logic               pc_write,
  output logic               ir_write,
  output logic               jumpSrc,
  output logic               PCSrc,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               MemRead,
  output logic               RegDst,
  output logic               ALUSrc,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic               illegal_op,
`endif
  output logic               busy_muldiv
);

  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  state_e               state;
  logic [INSTR_W-1:0]   ir;
  logic [CNT_W-1:0]     lat_cnt;
  iclass_e              cls;
  logic [3:0]           dec_alu;
  logic [SHAMT_W-1:0]   dec_shamt;
  logic                 legal;

  ctrl_decode #(.INSTR_W(INSTR_W), .SHAMT_W(SHAMT_W)) u_decode (
    .ir     (ir),
    .cls    (cls),
    .alu_op (dec_alu),
    .shamt  (dec_shamt),
    .legal  (legal)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      ir      <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir    <= instr_in;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (!legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state <= S_TRAP;
`else
            state <= S_FETCH;
`endif
          end else if (cls == CLS_J) begin
            state <= S_FETCH;
          end else if (cls == CLS_MULDIV) begin
            lat_cnt <= CNT_W'(MULDIV_LAT - 1);
            state   <= S_MULDIV;
          end else begin
            state <= S_EXEC;
          end
        end
        // Counter was loaded with LAT-1, so this state lasts exactly LAT cycles.
        S_MULDIV: if (lat_cnt == '0) state <= S_WB;
                  else lat_cnt <= lat_cnt - 1'b1;
        S_EXEC: begin
          if (cls == CLS_LW || cls == CLS_SW)       state <= S_MEM;
          else if (cls == CLS_BEQ || cls == CLS_BNE) state <= S_FETCH;
          else                                       state <= S_WB;
        end
        S_MEM: if (mem_ready) state <= (cls == CLS_LW) ? S_WB : S_FETCH;
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign instr = ir;

  // Controls are forced low while reset is asserted so the datapath sees no
  // strobe during reset, whatever the state register currently holds.
  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    jumpSrc      = 1'b0;
    PCSrc        = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    MemtoReg     = 1'b0;
    MemRead      = 1'b0;
    RegDst       = 1'b0;
    ALUSrc       = 1'b0;
    busy_muldiv  = 1'b0;
    alu_op       = '0;
    shift_amount = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_op   = 1'b0;
`endif
    if (!reset) begin
      // IR is stable from decode to writeback, so the decoded op is held too.
      if (state != S_FETCH && state != S_TRAP) begin
        alu_op       = ALUOP_W'(dec_alu);
        shift_amount = dec_shamt;
      end
      case (state)
        S_FETCH: begin
          MemRead  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: if (cls == CLS_J) begin
          jumpSrc  = 1'b1;
          pc_write = 1'b1;
        end
        S_MULDIV: busy_muldiv = 1'b1;
        S_EXEC: begin
          case (cls)
            CLS_RTYPE:     RegDst = 1'b1;
            CLS_LW, CLS_SW: ALUSrc = 1'b1;
            CLS_BEQ: begin pc_write = zero;  PCSrc = zero;  end
            CLS_BNE: begin pc_write = !zero; PCSrc = !zero; end
            default: ;
          endcase
        end
        S_MEM: begin
          MemRead  = (cls == CLS_LW);
          MemWrite = (cls == CLS_SW);
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = (cls == CLS_LW);
          RegDst   = (cls == CLS_RTYPE || cls == CLS_MULDIV);
        end
        S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          illegal_op = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized self-checking bench for multicycle_control.
// A reference model expands each instruction into its expected per-cycle
// control sequence from the instruction's kind and the chosen stalls.
module tb_multicycle_control;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset, mem_ready, zero;
  logic [31:0] instr_in, instr;
  logic [3:0]  alu_op;
  logic [4:0]  shift_amount;
  logic        pc_write, ir_write, jumpSrc, PCSrc, RegWrite, MemWrite;
  logic        MemtoReg, MemRead, RegDst, ALUSrc, busy_muldiv;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.INSTR_W(32), .ALUOP_W(4), .SHAMT_W(5), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready), .zero(zero),
    .instr(instr), .alu_op(alu_op), .shift_amount(shift_amount),
    .pc_write(pc_write), .ir_write(ir_write), .jumpSrc(jumpSrc), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .RegDst(RegDst), .ALUSrc(ALUSrc),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .busy_muldiv(busy_muldiv)
  );

  typedef struct packed {
    logic       ir_write, pc_write, jump_src, pc_src, reg_write, mem_write;
    logic       mem_to_reg, mem_read, reg_dst, alu_src, busy;
    logic [3:0] alu;
    logic [4:0] shamt;
  } ctrl_t;

  typedef struct { logic ready; logic zval; ctrl_t exp; } step_t;

  typedef enum { K_ALU, K_SHIFT, K_MUL, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_BAD } kind_t;

  logic [3:0] funct_alu [logic [5:0]];
  logic [3:0] op_alu    [logic [5:0]];
  kind_t      op_kind   [logic [5:0]];
  logic [5:0] funct_list [12];

  function automatic ctrl_t observed();
    return {ir_write, pc_write, jumpSrc, PCSrc, RegWrite, MemWrite, MemtoReg,
            MemRead, RegDst, ALUSrc, busy_muldiv, alu_op, shift_amount};
  endfunction

  task automatic init_tables();
    funct_alu[6'h20] = 4'b0100; funct_alu[6'h22] = 4'b0101; funct_alu[6'h24] = 4'b0000;
    funct_alu[6'h25] = 4'b0001; funct_alu[6'h26] = 4'b0010; funct_alu[6'h27] = 4'b0011;
    funct_alu[6'h2a] = 4'b0110; funct_alu[6'h00] = 4'b1011; funct_alu[6'h02] = 4'b1010;
    funct_alu[6'h03] = 4'b1001; funct_alu[6'h18] = 4'b1000; funct_alu[6'h1a] = 4'b0111;
    op_alu[6'b100011] = 4'b0100; op_kind[6'b100011] = K_LW;
    op_alu[6'b101011] = 4'b0100; op_kind[6'b101011] = K_SW;
    op_alu[6'b000100] = 4'b0101; op_kind[6'b000100] = K_BEQ;
    op_alu[6'b000101] = 4'b0101; op_kind[6'b000101] = K_BNE;
    op_alu[6'b000010] = 4'b1111; op_kind[6'b000010] = K_J;
    funct_list = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                   6'h2a, 6'h00, 6'h02, 6'h03, 6'h18, 6'h1a};
  endtask

  function automatic kind_t kind_of(input logic [31:0] ir);
    logic [5:0] op = ir[31:26];
    logic [5:0] fn = ir[5:0];
    if (op == 6'd0) begin
      if (!funct_alu.exists(fn)) return K_BAD;
      if (fn == 6'h18 || fn == 6'h1a) return K_MUL;
      if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) return K_SHIFT;
      return K_ALU;
    end
    if (op_kind.exists(op)) return op_kind[op];
    return K_BAD;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] ir);
    kind_t k = kind_of(ir);
    if (k == K_BAD) return 4'd0;
    if (ir[31:26] == 6'd0) return funct_alu[ir[5:0]];
    return op_alu[ir[31:26]];
  endfunction

  // Runs one instruction from fetch; stops early after max_steps cycles if >= 0.
  task automatic run_instr(input logic [31:0] ir, input int fs, input int ms,
                           input logic zval, input string name, input int max_steps = -1);
    step_t q[$];
    ctrl_t c, base;
    kind_t k = kind_of(ir);
    logic  taken;
    int    n;
    base       = '0;
    base.alu   = ref_alu(ir);
    base.shamt = (k == K_SHIFT) ? ir[10:6] : 5'd0;
    for (int i = 0; i < fs; i++) begin
      c = '0; c.mem_read = 1'b1; q.push_back('{1'b0, 1'($urandom), c});
    end
    c = '0; c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
    q.push_back('{1'b1, 1'($urandom), c});
    c = base;
    if (k == K_J) begin c.jump_src = 1'b1; c.pc_write = 1'b1; end
    q.push_back('{1'($urandom), 1'($urandom), c});
    case (k)
      K_ALU, K_SHIFT: begin
        c = base; c.reg_dst = 1'b1; q.push_back('{1'($urandom), 1'($urandom), c});
        c.reg_write = 1'b1;         q.push_back('{1'($urandom), 1'($urandom), c});
      end
      K_MUL: begin
        for (int i = 0; i < LAT; i++) begin
          c = base; c.busy = 1'b1; q.push_back('{1'($urandom), 1'($urandom), c});
        end
        c = base; c.reg_write = 1'b1; c.reg_dst = 1'b1;
        q.push_back('{1'($urandom), 1'($urandom), c});
      end
      K_LW, K_SW: begin
        c = base; c.alu_src = 1'b1; q.push_back('{1'($urandom), 1'($urandom), c});
        c = base;
        if (k == K_LW) c.mem_read = 1'b1; else c.mem_write = 1'b1;
        for (int i = 0; i < ms; i++) q.push_back('{1'b0, 1'($urandom), c});
        q.push_back('{1'b1, 1'($urandom), c});
        if (k == K_LW) begin
          c = base; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
          q.push_back('{1'($urandom), 1'($urandom), c});
        end
      end
      K_BEQ, K_BNE: begin
        taken = (k == K_BEQ) ? zval : !zval;
        c = base; c.pc_write = taken; c.pc_src = taken;
        q.push_back('{1'($urandom), zval, c});
      end
      default: ;
    endcase
    n = (max_steps >= 0 && max_steps < q.size()) ? max_steps : q.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = q[i].ready;
      zero      = q[i].zval;
      instr_in  = (i <= fs) ? ir : $urandom();
      #1;
      n_checks++;
      if (observed() !== q[i].exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d ir=%h: controls got %h expected %h",
                 name, i, ir, observed(), q[i].exp);
      end
      if (i == fs + 1) begin
        n_checks++;
        if (instr !== ir) begin
          n_fail++;
          $display("FAIL %s instr: got %h expected %h", name, instr, ir);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_quiet(input string name);
    #1;
    n_checks++;
    if (observed() !== ctrl_t'(0) || instr !== 32'd0) begin
      n_fail++;
      $display("FAIL %s: controls got %h instr got %h expected all zero", name, observed(), instr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; instr_in = $urandom();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
`ifdef CTRL_ILLEGAL_TRAP_EN
    n_checks++;
    if (illegal_op !== 1'b0) begin
      n_fail++; $display("FAIL reset illegal_op: got %b expected 0", illegal_op);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_add();
    run_instr({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 0, 0, 1'b0, "add");
  endtask

  task automatic test_lw_stall();
    run_instr({6'b100011, 5'd4, 5'd5, 16'h0010}, 0, 2, 1'b0, "lw_stall");
    run_instr({6'b101011, 5'd4, 5'd5, 16'h0020}, 2, 1, 1'b0, "sw_stall");
  endtask

  task automatic test_branch();
    run_instr({6'b000100, 5'd1, 5'd2, 16'h0004}, 0, 0, 1'b1, "beq_taken");
    run_instr({6'b000100, 5'd1, 5'd2, 16'h0004}, 0, 0, 1'b0, "beq_not");
    run_instr({6'b000101, 5'd1, 5'd2, 16'h0004}, 0, 0, 1'b1, "bne_not");
    run_instr({6'b000101, 5'd1, 5'd2, 16'h0004}, 0, 0, 1'b0, "bne_taken");
    run_instr({6'b000010, 26'h0abcdef}, 1, 0, 1'b0, "jump");
  endtask

  task automatic test_muldiv();
    run_instr({6'd0, 5'd6, 5'd7, 5'd0, 5'd0, 6'h18}, 0, 0, 1'b0, "mul");
    run_instr({6'd0, 5'd6, 5'd7, 5'd0, 5'd0, 6'h1a}, 1, 0, 1'b0, "div");
  endtask

  task automatic test_shift();
    run_instr({6'd0, 5'd0, 5'd2, 5'd3, 5'd13, 6'h00}, 0, 0, 1'b0, "sll13");
    run_instr({6'd0, 5'd0, 5'd2, 5'd3, 5'd31, 6'h03}, 0, 0, 1'b0, "sra31");
  endtask

  task automatic test_reset_muldiv();
    run_instr({6'd0, 5'd6, 5'd7, 5'd0, 5'd0, 6'h18}, 0, 0, 1'b0, "mul_pre_reset", 4);
    reset = 1'b1; mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_quiet("reset_in_muldiv");
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    n_checks++;
    if (MemRead !== 1'b1 || busy_muldiv !== 1'b0 || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_fetch: MemRead=%b busy=%b RegWrite=%b expected 1 0 0",
               MemRead, busy_muldiv, RegWrite);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
    run_instr({6'b111111, 26'h1234567}, 0, 0, 1'b0, "illegal_pre_trap");
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom); zero = 1'($urandom);
      #1;
      n_checks++;
      if (illegal_op !== 1'b1 || observed() !== ctrl_t'(0)) begin
        n_fail++;
        $display("FAIL trap cycle %0d: illegal_op=%b controls=%h expected 1 and 0",
                 i, illegal_op, observed());
      end
      @(posedge clk);
      @(negedge clk);
    end
    test_reset();
`else
    run_instr({6'b111111, 26'h1234567}, 0, 0, 1'b0, "illegal_nop");
    run_instr({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3f}, 0, 0, 1'b0, "bad_funct_nop");
`endif
    run_instr({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, 0, 0, 1'b0, "or_after_illegal");
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom();
`ifdef CTRL_ILLEGAL_TRAP_EN
    int pick = $urandom_range(0, 7);
`else
    int pick = $urandom_range(0, 8);
`endif
    case (pick)
      0, 1: begin r[31:26] = 6'd0; r[5:0] = funct_list[$urandom_range(0, 11)]; end
      2: r[31:26] = 6'b100011;
      3: r[31:26] = 6'b101011;
      4: r[31:26] = 6'b000100;
      5: r[31:26] = 6'b000101;
      6: r[31:26] = 6'b000010;
      7: begin r[31:26] = 6'd0; r[5:0] = ($urandom_range(0, 1) != 0) ? 6'h18 : 6'h1a; end
      default: r[31:26] = 6'b111111;
    endcase
    return r;
  endfunction

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), "random");
  endtask

  initial begin
    init_tables();
    test_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_muldiv();
    test_shift();
    test_reset_muldiv();
    test_illegal();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
